// File: rtl/pipelined_array_mult.sv
// Pipelined AND-array multiplier summing ROWS_PER_STAGE partial-product rows per stage under one global stall enable.
// Define PIPELINED_ARRAY_MULT_SIGNED_EN to build the Baugh-Wooley signed mode selected per transaction by sgn.
module pipelined_array_mult #(
  parameter int WIDTH          = 8,
  parameter int ROWS_PER_STAGE = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 sgn,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   p
);
  localparam int LAT = WIDTH / ROWS_PER_STAGE;
  localparam int PW  = 2 * WIDTH;

  logic              en;
  logic [LAT:0]      valid_q;
  logic [PW-1:0]     sum_q [0:LAT];
  logic [PW-1:0]     sum_d [1:LAT];
  logic [WIDTH-1:0]  opA_q [0:LAT-1];
  logic [WIDTH-1:0]  opB_q [0:LAT-1];
  logic [PW-1:0]     initSum;

`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
  // Inverting the sign-bearing partial products leaves a fixed offset of +2^WIDTH and +2^(PW-1).
  localparam logic [PW-1:0] BW_CONST = (PW'(1) << (PW - 1)) | (PW'(1) << WIDTH);

  logic [LAT-1:0] sgn_q;

  function automatic logic [WIDTH-1:0] bwMask(input int row);
    logic [WIDTH-1:0] msb;
    msb = WIDTH'(1) << (WIDTH - 1);
    return (row == WIDTH - 1) ? ~msb : msb;
  endfunction

  assign initSum = sgn ? BW_CONST : '0;
`else
  logic unusedSgn;
  assign unusedSgn = sgn;
  assign initSum   = '0;
`endif

  assign en        = !valid_q[LAT] || out_ready;
  assign in_ready  = en;
  assign out_valid = valid_q[LAT];
  assign p         = sum_q[LAT];

  always_comb begin
    int row;
    row = 0;
    for (int s = 1; s <= LAT; s++) begin
      sum_d[s] = sum_q[s-1];
      for (int r = 0; r < ROWS_PER_STAGE; r++) begin
        row = (s - 1) * ROWS_PER_STAGE + r;
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
        sum_d[s] = sum_d[s] + (PW'((opA_q[s-1] & {WIDTH{opB_q[s-1][row]}})
                                   ^ (sgn_q[s-1] ? bwMask(row) : '0)) << row);
`else
        sum_d[s] = sum_d[s] + (PW'(opA_q[s-1] & {WIDTH{opB_q[s-1][row]}}) << row);
`endif
      end
    end
  end

  // Payload registers only load behind a valid bit, so p keeps its last product across bubbles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int s = 0; s <= LAT; s++) begin
        sum_q[s] <= '0;
      end
      for (int s = 0; s < LAT; s++) begin
        opA_q[s] <= '0;
        opB_q[s] <= '0;
      end
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
      sgn_q <= '0;
`endif
    end else if (en) begin
      valid_q <= {valid_q[LAT-1:0], in_valid};
      if (in_valid) begin
        opA_q[0] <= a;
        opB_q[0] <= b;
        sum_q[0] <= initSum;
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
        sgn_q[0] <= sgn;
`endif
      end
      for (int s = 1; s < LAT; s++) begin
        if (valid_q[s-1]) begin
          opA_q[s] <= opA_q[s-1];
          opB_q[s] <= opB_q[s-1];
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
          sgn_q[s] <= sgn_q[s-1];
`endif
        end
      end
      for (int s = 1; s <= LAT; s++) begin
        if (valid_q[s-1]) begin
          sum_q[s] <= sum_d[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_array_mult.sv
// Self-checking bench for pipelined_array_mult: directed cases plus random streams against a delay-line product model.
// Honours PIPELINED_ARRAY_MULT_SIGNED_EN so the model matches the build under test.
module tb_pipelined_array_mult;
  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, sgn, out_valid, out_ready;
  logic [7:0]  a, b;
  logic [15:0] p;

  logic        inValid16, inReady16, sgn16, outValid16, outReady16;
  logic [15:0] a16, b16;
  logic [31:0] p16;

  int checks   = 0;
  int failures = 0;

  logic        mValid [LAT];
  logic [15:0] mProd  [LAT];
  logic        mOutV;
  logic [15:0] mOutP;

  always #5 clk = ~clk;

  pipelined_array_mult #(.WIDTH(8), .ROWS_PER_STAGE(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sgn(sgn), .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  pipelined_array_mult #(.WIDTH(16), .ROWS_PER_STAGE(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(inValid16), .in_ready(inReady16),
    .a(a16), .b(b16), .sgn(sgn16), .out_valid(outValid16), .out_ready(outReady16), .p(p16)
  );

  // Reference product from plain integer arithmetic.
  function automatic logic [15:0] refProduct(input logic [7:0] x, input logic [7:0] y, input logic s);
    int prod;
    prod = int'(x) * int'(y);
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
    if (s) prod = int'($signed(x)) * int'($signed(y));
`else
    if (s) prod = int'(x) * int'(y);
`endif
    return prod[15:0];
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < LAT; i++) begin
      mValid[i] = 1'b0;
      mProd[i]  = '0;
    end
    mOutV = 1'b0;
    mOutP = '0;
  endtask

  // Advance the model across one rising edge using the inputs currently driven.
  task automatic modelEdge();
    if (!mOutV || out_ready) begin
      if (mValid[LAT-1]) begin
        mOutV = 1'b1;
        mOutP = mProd[LAT-1];
      end else begin
        mOutV = 1'b0;
      end
      for (int i = LAT - 1; i > 0; i--) begin
        mValid[i] = mValid[i-1];
        mProd[i]  = mProd[i-1];
      end
      mValid[0] = in_valid;
      mProd[0]  = refProduct(a, b, sgn);
    end
  endtask

  task automatic checkOutput();
    checkVal("in_ready", 32'(in_ready), 32'(!mOutV || out_ready));
    checkVal("out_valid", 32'(out_valid), 32'(mOutV));
    checkVal("p", 32'(p), 32'(mOutP));
  endtask

  // One cycle: drive at the falling edge, compare, step the model, then settle past the rising edge.
  task automatic applyStimulus(input logic v, input logic [7:0] aa, input logic [7:0] bb,
                               input logic s, input logic ordy);
    @(negedge clk);
    in_valid  = v;
    a         = aa;
    b         = bb;
    sgn       = s;
    out_ready = ordy;
    #1;
    checkOutput();
    modelEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sgn = 1'b0; out_ready = 1'b1;
    inValid16 = 1'b0; a16 = '0; b16 = '0; sgn16 = 1'b0; outReady16 = 1'b1;
    modelReset();
    #12;
    checkVal("reset_in_ready", 32'(in_ready), 32'd1);
    checkVal("reset_out_valid", 32'(out_valid), 32'd0);
    checkVal("reset_p", 32'(p), 32'd0);
    checkVal("reset_p16", p16, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 255*255 alongside the 16-bit instance doing 0xFFFF*2.
    inValid16 = 1'b1; a16 = 16'hFFFF; b16 = 16'h0002;
    applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b0, 1'b1);
    inValid16 = 1'b0;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkVal("lat_early_out_valid", 32'(out_valid), 32'd0);
    checkVal("lat_early_out_valid16", 32'(outValid16), 32'd0);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkVal("ff_x_ff_valid", 32'(out_valid), 32'd1);
    checkVal("ff_x_ff_p", 32'(p), 32'h0000FE01);
    checkVal("w16_valid", 32'(outValid16), 32'd1);
    checkVal("w16_p", p16, 32'h0001FFFE);

    // Signed corner cases, back to back.
    applyStimulus(1'b1, 8'h80, 8'h80, 1'b1, 1'b1);
    applyStimulus(1'b1, 8'hFF, 8'h01, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkVal("s80_x_80_p", 32'(p), 32'h00004000);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
`ifdef PIPELINED_ARRAY_MULT_SIGNED_EN
    checkVal("sff_x_01_p", 32'(p), 32'h0000FFFF);
`else
    checkVal("sff_x_01_p", 32'(p), 32'h000000FF);
`endif
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    checkVal("hold_after_drain_p", 32'(p), 32'(mOutP));

    // Random streaming at full rate.
    for (int i = 0; i < 16; i++)
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Random stream with a three-cycle output stall mid-stream.
    for (int i = 0; i < 12; i++)
      applyStimulus(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), !(i >= 5 && i < 8));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Random valid/ready mix.
    for (int i = 0; i < 20; i++)
      applyStimulus(1'($urandom), 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    // Reset pulse between edges with work in flight and a product on the output.
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 8'($urandom_range(1, 255)), 8'($urandom_range(1, 255)), 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    checkVal("pre_reset_out_valid", 32'(out_valid), 32'd1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkVal("midreset_out_valid", 32'(out_valid), 32'd0);
    checkVal("midreset_p", 32'(p), 32'd0);
    checkVal("midreset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/pipelined_array_mult.md
PIPELINED_ARRAY_MULT -- requirements
Module: pipelined_array_mult

Interface
REQ-001 Parameter WIDTH, default 8, operand width in bits; legal range 4..32.
REQ-002 Parameter ROWS_PER_STAGE, default 2, number of partial-product rows summed between pipeline registers; WIDTH % ROWS_PER_STAGE SHALL be 0.
REQ-003 Derived constant LAT = WIDTH / ROWS_PER_STAGE, the pipeline depth in cycles (4 at defaults).
REQ-004 clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid  input  1  operands present on a, b and sgn.
REQ-007 in_ready  output  1  the block accepts operands this cycle.
REQ-008 a  input  WIDTH  multiplicand.
REQ-009 b  input  WIDTH  multiplier.
REQ-010 sgn  input  1  per-transaction mode: 1 = two's-complement signed, 0 = unsigned.
REQ-011 out_valid  output  1  p holds a completed product.
REQ-012 out_ready  input  1  downstream consumes p this cycle.
REQ-013 p  output  2*WIDTH  product.

Function
REQ-014 Datapath: AND-gate partial products, accumulated row by row as in the 8-bit array multiplier; ROWS_PER_STAGE rows per stage; LAT register stages, each carrying a valid bit, sgn, the remaining operand bits and the partial sum.
REQ-015 Accept: a transaction is accepted on a rising edge where in_valid && in_ready.
REQ-016 Global enable: en = !out_valid || out_ready; in_ready SHALL equal en combinationally; when en = 0 no stage register changes.
REQ-017 Latency: a transaction accepted at edge k with en held high SHALL present out_valid = 1 with its p after edge k+LAT.
REQ-018 Throughput: one transaction per cycle while en = 1; bubbles (in_valid = 0) propagate as valid = 0 stages.
REQ-019 Ordering: results SHALL leave in acceptance order; none lost or duplicated under any out_ready pattern.
REQ-020 Output hold: while out_valid && !out_ready, p and out_valid SHALL stay stable.
REQ-021 Unsigned: p = a * b exactly, zero-extended operands, modulo 2^(2*WIDTH) (never overflows).
REQ-022 Signed: p = a * b with both operands sign-extended, using Baugh-Wooley correction of the final-row and MSB partial products; the result is an exact 2*WIDTH two's-complement value.
REQ-023 Simultaneous events: a stage draining to the output and a new accept on the same edge SHALL both complete.
REQ-024 When out_valid = 0, p SHALL hold its last value (0 after reset).

Reset
REQ-025 rst_n low SHALL asynchronously clear all stage valid bits, out_valid and p to 0, independent of clk.
REQ-026 Reset mid-operation SHALL discard all in-flight transactions; no stale product appears after release.
REQ-027 in_ready SHALL read 1 during and after reset (pipeline empty).
REQ-028 The first accept SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-029 Macro PIPELINED_ARRAY_MULT_SIGNED_EN: when defined, sgn selects signed or unsigned per REQ-021/022.
REQ-030 When undefined, the Baugh-Wooley correction logic is not built; sgn is ignored and every transaction is unsigned.

Verification
REQ-031 WIDTH=8, RPS=2, unsigned: a=255, b=255 accepted at edge 0 -> out_valid after edge 4, p=0xFE01.
REQ-032 Signed (macro defined): a=0x80, b=0x80, sgn=1 -> p=0x4000; a=0xFF, b=0x01, sgn=1 -> p=0xFFFF; same with macro undefined -> p=0x00FF.
REQ-033 Streaming: 16 random pairs on consecutive cycles, out_ready=1 -> 16 correct products on 16 consecutive cycles, starting 4 cycles after the first accept.
REQ-034 Backpressure: out_ready low for 3 cycles mid-stream -> in_ready low for those same 3 cycles, p stable, all results correct and in order.
REQ-035 Reset mid-flight: 3 transactions accepted, rst_n pulsed low for 1 ns between edges -> out_valid=0 and p=0 immediately; no product emitted after release.
REQ-036 Parameter sweep: WIDTH=16, RPS=4, a=0xFFFF, b=0x0002, unsigned -> p=0x0001FFFE after 4 cycles.
